// File: rtl/crossbar_rsp_return_if.sv
// Bank-side and lane-side handshake bundle of the crossbar response return path.
// The slave modport is the crossbar's view; the master modport drives banks and lane readies.
interface crossbar_rsp_return_if #(
    parameter int NUM_LANES = 4,
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 64,
    parameter int LANE_ID_W = 2,
    parameter int BANK_ID_W = 2
);
    logic [NUM_BANKS-1:0]           bank_rsp_valid;
    logic [NUM_BANKS*LANE_ID_W-1:0] bank_rsp_lane;
    logic [NUM_BANKS*DATA_W-1:0]    bank_rsp_data;
    logic [NUM_BANKS-1:0]           bank_rsp_ready;
    logic [NUM_LANES-1:0]           lane_rsp_valid;
    logic [NUM_LANES*DATA_W-1:0]    lane_rsp_data;
    logic [NUM_LANES*BANK_ID_W-1:0] lane_rsp_bank;
    logic [NUM_LANES-1:0]           lane_rsp_ready;

    modport slave (
        input  bank_rsp_valid, bank_rsp_lane, bank_rsp_data, lane_rsp_ready,
        output bank_rsp_ready, lane_rsp_valid, lane_rsp_data, lane_rsp_bank
    );

    modport master (
        output bank_rsp_valid, bank_rsp_lane, bank_rsp_data, lane_rsp_ready,
        input  bank_rsp_ready, lane_rsp_valid, lane_rsp_data, lane_rsp_bank
    );
endinterface

// File: rtl/crossbar_rsp_return.sv
// Routes tagged bank read responses to per-lane output registers with per-lane round-robin arbitration.
// Optional per-bank stall counters are enabled by defining XBAR_RSP_STALL_CNT_EN.
module crossbar_rsp_return #(
    parameter int NUM_LANES = 4,
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 64,
    parameter int LANE_ID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    parameter int BANK_ID_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    crossbar_rsp_return_if.slave  bus,
    output logic                  lane_id_err
`ifdef XBAR_RSP_STALL_CNT_EN
    ,
    output logic [NUM_BANKS*16-1:0] stall_cnt
`endif
);

    logic [LANE_ID_W-1:0] bank_lane [NUM_BANKS];
    logic [NUM_BANKS-1:0] oor;
    logic [NUM_BANKS-1:0] lane_grant [NUM_LANES];
    logic [NUM_BANKS-1:0] grant_any;
    logic                 err_q, err_d;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        assign bank_lane[gi] = bus.bank_rsp_lane[gi*LANE_ID_W +: LANE_ID_W];
        // Out-of-range tags only exist when the tag width can encode more than NUM_LANES.
        if ((1 << LANE_ID_W) > NUM_LANES) begin : g_oor
            assign oor[gi] = bus.bank_rsp_valid[gi] && (bank_lane[gi] >= LANE_ID_W'(NUM_LANES));
        end else begin : g_no_oor
            assign oor[gi] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [NUM_BANKS-1:0] req;
        logic [NUM_BANKS-1:0] req_rot;
        logic [NUM_BANKS-1:0] grant_oh;
        logic                 can_load;
        logic                 grant_vld;
        logic [BANK_ID_W-1:0] grant_idx;
        logic [BANK_ID_W-1:0] ptr_q, ptr_d;
        logic [BANK_ID_W-1:0] bank_q, bank_d;
        logic [DATA_W-1:0]    data_q, data_d;
        logic                 valid_q, valid_d;

        always_comb begin
            req = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                req[b] = bus.bank_rsp_valid[b] && (bank_lane[b] == LANE_ID_W'(gi));
            end
        end

        assign can_load = !valid_q || bus.lane_rsp_ready[gi];
        // Rotating by the pointer turns the cyclic search into a lowest-bit-first search.
        assign req_rot  = NUM_BANKS'({req, req} >> ptr_q);

        always_comb begin
            int sel;
            sel       = 0;
            grant_idx = '0;
            for (int off = NUM_BANKS - 1; off >= 0; off--) begin
                if (req_rot[off]) begin
                    sel = int'(ptr_q) + off;
                    if (sel >= NUM_BANKS) sel = sel - NUM_BANKS;
                    grant_idx = BANK_ID_W'(sel);
                end
            end
            grant_vld = (|req) && can_load && !reset;
        end

        assign grant_oh = grant_vld ? (NUM_BANKS'(1) << grant_idx) : '0;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            bank_d  = bank_q;
            ptr_d   = ptr_q;
            if (grant_vld) begin
                valid_d = 1'b1;
                data_d  = bus.bank_rsp_data[int'(grant_idx)*DATA_W +: DATA_W];
                bank_d  = grant_idx;
                ptr_d   = (grant_idx == BANK_ID_W'(NUM_BANKS - 1)) ? '0 : grant_idx + BANK_ID_W'(1);
            end else if (valid_q && bus.lane_rsp_ready[gi]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                bank_q  <= '0;
                ptr_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                bank_q  <= bank_d;
                ptr_q   <= ptr_d;
            end
        end

        assign lane_grant[gi]                                  = grant_oh;
        assign bus.lane_rsp_valid[gi]                          = valid_q;
        assign bus.lane_rsp_data[gi*DATA_W +: DATA_W]          = data_q;
        assign bus.lane_rsp_bank[gi*BANK_ID_W +: BANK_ID_W]    = bank_q;
    end

    always_comb begin
        grant_any = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            grant_any = grant_any | lane_grant[l];
        end
    end

    // Out-of-range responses are accepted so the bank is never blocked by a bad tag.
    assign bus.bank_rsp_ready = reset ? '0 : (grant_any | oor);

    assign err_d = err_q | (|oor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign lane_id_err = err_q;

`ifdef XBAR_RSP_STALL_CNT_EN
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_stall
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (bus.bank_rsp_valid[gi] && !bus.bank_rsp_ready[gi] && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        assign stall_cnt[gi*16 +: 16] = cnt_q;
    end
`endif

endmodule
